// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: issues sequential word fetches to a variable-latency instruction memory,
// buffers PC-tagged responses in an in-order queue and flushes on execute redirects.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [31:0] f_pc,
  output logic [31:0] f_instruction,
  output logic        misaligned_redirect
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]      fetch_pc;
  logic [31:0]      rsp_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] drop_cnt;
  logic             misaligned_q;

  logic [31:0] q_pc    [QUEUE_DEPTH];
  logic [31:0] q_instr [QUEUE_DEPTH];

  logic [31:0] committed_slots;
  logic        req_fire;
  logic        rsp_fire;
  logic        rsp_drop;
  logic        push;
  logic        pop;

  // Handshakes: a transfer happens on a clock edge where valid && ready are both high;
  // a request holds valid and address stable until accepted (unless redirect/reset intervenes).
  // Queue slots already claimed: stored entries plus responses that will be kept.
  always_comb begin
    committed_slots = 32'(count) + 32'(outstanding) - 32'(drop_cnt);
  end

  assign imem_req_valid = !reset && !redirect_valid
                        && (32'(outstanding) < 32'(MAX_OUTSTANDING))
                        && (committed_slots < 32'(QUEUE_DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop = (drop_cnt != '0);
  assign push     = !reset && !redirect_valid && rsp_fire && !rsp_drop;

  assign f_valid             = (count != '0) && !redirect_valid;
  assign f_pc                = q_pc[rd_ptr];
  assign f_instruction       = q_instr[rd_ptr];
  assign pop                 = f_valid && f_ready;
  assign misaligned_redirect = misaligned_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      rsp_pc       <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      outstanding  <= '0;
      drop_cnt     <= '0;
      misaligned_q <= 1'b0;
    end else if (redirect_valid) begin
      // Every request still in flight (minus one answered now) returns stale data.
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      rsp_pc      <= {redirect_pc[31:2], 2'b00};
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - OUT_W'(rsp_fire);
      drop_cnt    <= outstanding - OUT_W'(rsp_fire);
      if (redirect_pc[1:0] != 2'b00) misaligned_q <= 1'b1;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + OUT_W'(req_fire) - OUT_W'(rsp_fire);
      if (rsp_fire && rsp_drop) drop_cnt <= drop_cnt - OUT_W'(1);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr]    <= rsp_pc;
      q_instr[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order memory model with programmable latency and a
// scoreboard of expected {pc, instruction} pairs checked on every decode pop.
module tb_fetch_prefetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_pc;
  logic [31:0] f_instruction;
  logic        misaligned_redirect;

  fetch_prefetch_unit #(
    .RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(4)
  ) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_instruction(f_instruction),
    .misaligned_redirect(misaligned_redirect)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  int          edge_n = 0;
  int          mem_lat = 1;
  int          acc_count = 0;
  int          pop_count = 0;
  logic [31:0] acc_log[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] exp_q[$];
  logic [63:0] pop_e;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      exp_q.push_back({a, mem_word(a)});
    end
  endtask

  // Observe just before each rising edge: record accepted requests, consumed responses, pops.
  always @(negedge clock) begin
    #4;
    if (imem_rsp_valid && pend_addr.size() > 0) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(edge_n + mem_lat);
      acc_log.push_back(imem_req_addr);
      acc_count++;
    end
    if (prev_stall && !reset && !redirect_valid) begin
      check("req_hold_valid", imem_req_valid, 1);
      check("req_hold_addr", imem_req_addr, prev_addr);
    end
    prev_stall = imem_req_valid && !imem_req_ready;
    prev_addr  = imem_req_addr;
    if (f_valid && f_ready) begin
      pop_count++;
      check("pop_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        pop_e = exp_q.pop_front();
        check("f_pc", f_pc, pop_e[63:32]);
        check("f_instruction", f_instruction, pop_e[31:0]);
      end
    end
    edge_n++;
  end

  // Memory responds in order once each request's latency has elapsed.
  always @(negedge clock) begin
    if (pend_addr.size() > 0 && pend_due[0] <= edge_n) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // Driver tasks
  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    redirect_valid = 1'b0;
    f_ready = 1'b0;
    exp_q.delete();
    repeat (cycles) @(negedge clock);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_f_valid", f_valid, 0);
    check("rst_misaligned", misaligned_redirect, 0);
    acc_count = 0;
    acc_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int max_cycles);
    for (int i = 0; i < max_cycles && acc_count < n; i++) @(negedge clock);
    check("acc_count_reached", acc_count, n);
  endtask

  task automatic drain(input int max_cycles);
    f_ready = 1'b1;
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clock);
    check("drain_done", exp_q.size(), 0);
    f_ready = 1'b0;
  endtask

  task automatic redirect_one(input logic [31:0] pc);
    @(negedge clock);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; f_ready = 1'b0; mem_lat = 1;

    // Startup latency and steady-state throughput
    do_reset(3);
    push_exp(32'h0, 12);
    f_ready = 1'b1;
    #1;
    check("c1_req_valid", imem_req_valid, 1);
    check("c1_req_addr", imem_req_addr, 32'h0);
    check("c1_f_valid", f_valid, 0);
    @(negedge clock); #1;
    check("c2_f_valid", f_valid, 0);
    @(negedge clock); #1;
    check("c3_f_valid", f_valid, 1);
    check("c3_f_pc", f_pc, 32'h0);
    p0 = pop_count;
    repeat (8) @(negedge clock);
    check("throughput_8", pop_count - p0, 8);
    drain(40);

    // Backpressure: queue fills to exactly four, then drains in order
    do_reset(3);
    repeat (10) @(negedge clock);
    #1;
    check("full_acc_count", acc_count, 4);
    check("full_req_valid", imem_req_valid, 0);
    check("full_f_valid", f_valid, 1);
    check("full_head_pc", f_pc, 32'h0);
    check("full_head_instr", f_instruction, mem_word(32'h0));
    push_exp(32'h0, 8);
    drain(40);

    // Redirect with three requests in flight on 3-cycle memory
    mem_lat = 3;
    do_reset(3);
    f_ready = 1'b1;
    wait_acc(3, 20);
    push_exp(32'h100, 6);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("redir_f_valid", f_valid, 0);
    check("redir_req_valid", imem_req_valid, 0);
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
    check("post_redir_req_valid", imem_req_valid, 1);
    check("post_redir_req_addr", imem_req_addr, 32'h100);
    drain(60);

    // Reset with responses still in flight: late responses must be ignored
    imem_req_ready = 1'b0;
    do_reset(1);
    repeat (7) @(negedge clock);
    #1;
    check("stale_after_reset_f_valid", f_valid, 0);
    check("stalled_req_valid", imem_req_valid, 1);
    check("stalled_req_addr", imem_req_addr, 32'h0);
    push_exp(32'h0, 6);
    imem_req_ready = 1'b1;
    drain(60);

    // Redirect colliding with a response and a pending pop
    mem_lat = 1;
    do_reset(3);
    wait_acc(4, 20);
    push_exp(32'h400, 4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    f_ready = 1'b1;
    #1;
    check("collide_f_valid", f_valid, 0);
    check("collide_req_valid", imem_req_valid, 0);
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
    check("flushed_f_valid", f_valid, 0);
    check("flushed_req_valid", imem_req_valid, 1);
    check("flushed_req_addr", imem_req_addr, 32'h400);
    drain(40);

    // Back-to-back redirects, the second misaligned; flag is sticky until reset
    push_exp(32'h200, 3);
    @(negedge clock);
    redirect_valid = 1'b1;
    redirect_pc = 32'h500;
    @(negedge clock);
    #1;
    check("aligned_no_flag", misaligned_redirect, 0);
    redirect_pc = 32'h203;
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
    check("misaligned_set", misaligned_redirect, 1);
    check("misaligned_req_addr", imem_req_addr, 32'h200);
    drain(40);
    push_exp(32'h300, 3);
    redirect_one(32'h300);
    check("misaligned_sticky", misaligned_redirect, 1);
    check("aligned_req_addr", imem_req_addr, 32'h300);
    drain(40);
    do_reset(2);

    // Address wrap at the top of the address space
    push_exp(32'hFFFF_FFF8, 5);
    @(negedge clock);
    acc_log.delete();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clock);
    redirect_valid = 1'b0;
    drain(40);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] want;
      want = 32'hFFFF_FFF8 + 32'(4 * i);
      check("wrap_req_addr", (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF, want);
    end

    // Report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
